// File: rtl/d_mem_sized.sv
// Byte-addressed data memory with byte/half/word access, sign/zero-extended loads,
// programmable wait states behind a Busy/Ready handshake, and an Error pulse for rejected requests.
module d_mem_sized #(
   parameter int MemSize    = 5,
   parameter int WaitStates = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  Size,
   input  logic        Unsigned,
   output logic [31:0] ReadData,
   output logic        Ready,
   output logic        Error,
   output logic        Busy
);

   localparam int Words = 1 << MemSize;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_next;
   logic [3:0]  count;
   logic [31:0] addr, wdata;
   logic [1:0]  size;
   logic        uns, op_rd, op_wr;
   logic [31:0] mem [Words];

   logic               request, accept, access, err;
   logic [MemSize-1:0] index;
   logic [1:0]         lane;
   logic [3:0]         byte_en;
   logic [31:0]        lane_data, word, load_value;
   logic [7:0]         byte_val;
   logic [15:0]        half_val;

   assign request = MemRead | MemWrite;
   // The DONE cycle already accepts the next request so a held request is taken every W+2 cycles.
   assign accept  = request && ((state == S_IDLE) || (state == S_DONE));
   assign access  = (state == S_WAIT) && (count == 4'd0);
   assign index   = addr[MemSize+1:2];
   assign lane    = addr[1:0];

   assign err = (|addr[31:MemSize+2])
              | (size == 2'b11)
              | ((size == 2'b01) && addr[0])
              | ((size == 2'b10) && (addr[1:0] != 2'b00))
              | (op_rd & op_wr);

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (request) state_next = S_WAIT; else state_next = S_IDLE;
         S_WAIT:  if (count == 4'd0) state_next = S_DONE; else state_next = S_WAIT;
         S_DONE:  if (request) state_next = S_WAIT; else state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      byte_en   = 4'b0000;
      lane_data = wdata;
      case (size)
         2'b00: begin
            byte_en   = 4'b0001 << lane;
            lane_data = {4{wdata[7:0]}};
         end
         2'b01: begin
            byte_en   = 4'b0011 << lane;
            lane_data = {2{wdata[15:0]}};
         end
         2'b10: begin
            byte_en   = 4'b1111;
            lane_data = wdata;
         end
         default: begin
            byte_en   = 4'b0000;
            lane_data = wdata;
         end
      endcase
   end

   always_comb begin
      word       = mem[index];
      byte_val   = word[{lane, 3'b000} +: 8];
      half_val   = word[{addr[1], 4'b0000} +: 16];
      load_value = word;
      case (size)
         2'b00: begin
            if (uns) load_value = {24'h000000, byte_val};
            else     load_value = {{24{byte_val[7]}}, byte_val};
         end
         2'b01: begin
            if (uns) load_value = {16'h0000, half_val};
            else     load_value = {{16{half_val[15]}}, half_val};
         end
         default: load_value = word;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         addr  <= 32'd0;
         wdata <= 32'd0;
         size  <= 2'b00;
         uns   <= 1'b0;
         op_rd <= 1'b0;
         op_wr <= 1'b0;
      end else if (accept) begin
         addr  <= Address;
         wdata <= WriteData;
         size  <= Size;
         uns   <= Unsigned;
         op_rd <= MemRead;
         op_wr <= MemWrite;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         count    <= 4'd0;
         Busy     <= 1'b0;
         Ready    <= 1'b0;
         Error    <= 1'b0;
         ReadData <= 32'd0;
      end else begin
         state <= state_next;
         Busy  <= (state_next != S_IDLE);
         Ready <= access;
         Error <= access & err;
         if (accept)
            count <= 4'(WaitStates);
         else if ((state == S_WAIT) && (count != 4'd0))
            count <= count - 4'd1;
         if (access) begin
            if (err || op_wr) ReadData <= 32'd0;
            else              ReadData <= load_value;
         end
      end
   end

   // Array has no reset; a reset on the access edge suppresses the write.
   always_ff @(posedge clock) begin
      if (access && op_wr && !err && !reset) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem[index][8*i +: 8] <= lane_data[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_d_mem_sized.sv
// Directed self-checking bench: one instance with no wait states, one with three.
module tb_d_mem_sized;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic [31:0] address, write_data;
   logic [1:0]  size;
   logic        uns;
   logic        reset0, rd0, wr0, reset3, rd3, wr3;
   logic [31:0] rdata0, rdata3;
   logic        ready0, error0, busy0, ready3, error3, busy3;
   int          nvec = 0;
   int          nerr = 0;

   d_mem_sized #(.MemSize(5), .WaitStates(0)) dut0 (
      .clock(clock), .reset(reset0), .Address(address), .WriteData(write_data),
      .MemRead(rd0), .MemWrite(wr0), .Size(size), .Unsigned(uns),
      .ReadData(rdata0), .Ready(ready0), .Error(error0), .Busy(busy0)
   );

   d_mem_sized #(.MemSize(5), .WaitStates(3)) dut3 (
      .clock(clock), .reset(reset3), .Address(address), .WriteData(write_data),
      .MemRead(rd3), .MemWrite(wr3), .Size(size), .Unsigned(uns),
      .ReadData(rdata3), .Ready(ready3), .Error(error3), .Busy(busy3)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One request on the chosen instance; checks latency, data and error at the Ready pulse.
   task automatic xact(input int w, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz, input logic u,
                       input string tag, input logic [31:0] exp_d, input logic exp_e);
      int lat;
      address = a; write_data = d; size = sz; uns = u;
      if (w == 3) begin rd3 = rd; wr3 = wr; end
      else        begin rd0 = rd; wr0 = wr; end
      @(posedge clock); #1;
      rd0 = 1'b0; wr0 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
      lat = 0;
      while ((((w == 3) ? ready3 : ready0) !== 1'b1) && (lat < 40)) begin
         @(posedge clock); #1;
         lat++;
      end
      chk({tag, " latency"}, 64'(lat), (w == 3) ? 64'd4 : 64'd1);
      chk({tag, " data"}, (w == 3) ? 64'(rdata3) : 64'(rdata0), 64'(exp_d));
      chk({tag, " error"}, (w == 3) ? 64'(error3) : 64'(error0), 64'(exp_e));
      @(posedge clock); #1;
   endtask

   logic [10:0] exp_busy  = 11'b01111111111;
   logic [10:0] exp_ready = 11'b01000010000;
   int          seen;

   initial begin
      address = 32'd0; write_data = 32'd0; size = 2'b00; uns = 1'b0;
      rd0 = 1'b0; wr0 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
      reset0 = 1'b1; reset3 = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      chk("reset w0", {rdata0, ready0, error0, busy0}, 64'd0);
      chk("reset w3", {rdata3, ready3, error3, busy3}, 64'd0);
      reset0 = 1'b0; reset3 = 1'b0;
      @(posedge clock); #1;

      xact(0, 1'b0, 1'b1, 32'h8,  32'hDEADBEEF, 2'b10, 1'b0, "sw 0x8",      32'h0,        1'b0);
      xact(0, 1'b1, 1'b0, 32'h8,  32'h0,        2'b10, 1'b0, "lw 0x8",      32'hDEADBEEF, 1'b0);
      xact(0, 1'b0, 1'b1, 32'h9,  32'h1234567F, 2'b00, 1'b0, "sb 0x9",      32'h0,        1'b0);
      xact(0, 1'b1, 1'b0, 32'h8,  32'h0,        2'b10, 1'b0, "lw after sb", 32'hDEAD7FEF, 1'b0);
      xact(0, 1'b1, 1'b0, 32'hB,  32'h0,        2'b00, 1'b0, "lb 0xB",      32'hFFFFFFDE, 1'b0);
      xact(0, 1'b1, 1'b0, 32'hB,  32'h0,        2'b00, 1'b1, "lbu 0xB",     32'h000000DE, 1'b0);
      repeat (3) @(posedge clock);
      #1;
      chk("readdata hold", 64'(rdata0), 64'h000000DE);

      xact(0, 1'b0, 1'b1, 32'h8,  32'h80001234, 2'b10, 1'b0, "sw 0x8 b",    32'h0,        1'b0);
      xact(0, 1'b1, 1'b0, 32'hA,  32'h0,        2'b01, 1'b0, "lh 0xA",      32'hFFFF8000, 1'b0);
      xact(0, 1'b1, 1'b0, 32'h8,  32'h0,        2'b01, 1'b1, "lhu 0x8",     32'h00001234, 1'b0);
      xact(0, 1'b1, 1'b0, 32'h9,  32'h0,        2'b01, 1'b0, "lh 0x9 misal", 32'h0,       1'b1);
      xact(0, 1'b0, 1'b1, 32'h9,  32'h0000FFFF, 2'b01, 1'b0, "sh 0x9 misal", 32'h0,       1'b1);
      xact(0, 1'b1, 1'b0, 32'h8,  32'h0,        2'b10, 1'b0, "lw unchanged", 32'h80001234, 1'b0);
      xact(0, 1'b0, 1'b1, 32'hA,  32'hABCD5678, 2'b01, 1'b0, "sh 0xA",      32'h0,        1'b0);
      xact(0, 1'b1, 1'b0, 32'h8,  32'h0,        2'b10, 1'b0, "lw after sh", 32'h56781234, 1'b0);

      xact(0, 1'b0, 1'b1, 32'h0,  32'h11111111, 2'b10, 1'b0, "sw 0x0",      32'h0,        1'b0);
      xact(0, 1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 2'b10, 1'b0, "sw 0x80 oor", 32'h0,        1'b1);
      xact(0, 1'b1, 1'b0, 32'h0,  32'h0,        2'b10, 1'b0, "lw 0x0 kept", 32'h11111111, 1'b0);
      xact(0, 1'b0, 1'b1, 32'h7C, 32'hA5A5A5A5, 2'b10, 1'b0, "sw 0x7C",     32'h0,        1'b0);
      xact(0, 1'b1, 1'b0, 32'h7C, 32'h0,        2'b10, 1'b0, "lw 0x7C",     32'hA5A5A5A5, 1'b0);
      xact(0, 1'b1, 1'b0, 32'h8,  32'h0,        2'b11, 1'b0, "size 11",     32'h0,        1'b1);
      xact(0, 1'b1, 1'b1, 32'h8,  32'h0,        2'b10, 1'b0, "rd and wr",   32'h0,        1'b1);

      // Reset on the same edge as a request drops the request.
      address = 32'h8; size = 2'b10; rd0 = 1'b1; reset0 = 1'b1;
      @(posedge clock); #1;
      rd0 = 1'b0; reset0 = 1'b0;
      chk("reset+req busy", 64'(busy0), 64'd0);
      @(posedge clock); #1;
      chk("reset+req dropped", {ready0, busy0}, 64'd0);

      xact(3, 1'b0, 1'b1, 32'h10, 32'h01020304, 2'b10, 1'b0, "w3 sw 0x10", 32'h0, 1'b0);
      xact(3, 1'b0, 1'b1, 32'h14, 32'h000000F0, 2'b10, 1'b0, "w3 sw 0x14", 32'h0, 1'b0);

      // Held MemRead: second load accepted at t+5 with the inputs changed mid-access.
      address = 32'h10; size = 2'b10; uns = 1'b0; rd3 = 1'b1;
      @(posedge clock); #1;
      address = 32'h14; size = 2'b00; write_data = 32'hFFFFFFFF;
      for (int k = 0; k < 11; k++) begin
         chk($sformatf("w3 busy k=%0d", k), 64'(busy3), 64'(exp_busy[k]));
         chk($sformatf("w3 ready k=%0d", k), 64'(ready3), 64'(exp_ready[k]));
         if (k == 4) chk("w3 first load", {rdata3, error3}, {32'h01020304, 1'b0});
         if (k == 9) chk("w3 second load", {rdata3, error3}, {32'hFFFFFFF0, 1'b0});
         if (k == 5) rd3 = 1'b0;
         @(posedge clock); #1;
      end

      // Reset mid-WAIT aborts the store.
      address = 32'h10; write_data = 32'hBBBBBBBB; size = 2'b10; wr3 = 1'b1;
      @(posedge clock); #1;
      wr3 = 1'b0;
      @(posedge clock); #1;
      reset3 = 1'b1;
      @(posedge clock); #1;
      reset3 = 1'b0;
      chk("w3 abort outputs", {rdata3, ready3, error3, busy3}, 64'd0);
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clock); #1;
         if (ready3 === 1'b1) seen++;
      end
      chk("w3 no ready after abort", 64'(seen), 64'd0);
      xact(3, 1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, "w3 lw 0x10 kept", 32'h01020304, 1'b0);
      xact(3, 1'b1, 1'b0, 32'h14, 32'h0, 2'b10, 1'b0, "w3 lw 0x14 kept", 32'h000000F0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
